// File: rtl/i2c_slave_responder.sv
// I2C target core: oversamples SCL/SDA on core_clk, detects START/STOP,
// matches a fixed 7-bit address, ACKs and delivers written bytes, and
// serves read bytes fetched from the user. Drives SDA low only; never
// touches SCL (no clock stretching).
//
// User handshakes (no back-pressure on either side):
//   rx_valid - one-cycle strobe; rx_data holds the new byte from that cycle
//              on. There is no ready: a missed strobe loses the byte.
//   tx_req   - one-cycle strobe at the ACK clock's rising edge; the user must
//              have the next byte on tx_data by the following SCL fall, when
//              it is latched. tx_data is ignored at all other times.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h10,
    parameter int         HOLD_CYCLES = 2
) (
    input  logic       core_clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       addr_match,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX_DATA   = 3'd3,
        RX_ACK    = 3'd4,
        TX_DATA   = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    localparam int            HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    state_t        state;
    logic          scl_s1, scl_s2, scl_h;
    logic          sda_s1, sda_s2, sda_h;
    logic [3:0]    bit_cnt;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    shift;
    logic [7:0]    tx_shift;
    logic          rw;
    logic          rx_pend;

    logic scl_rise, scl_fall, start_cond, stop_cond, hold_fire;

    assign scl_rise   = scl_s2 & ~scl_h;
    assign scl_fall   = ~scl_s2 & scl_h;
    assign start_cond = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_cond  = scl_s2 & scl_h & ~sda_h & sda_s2;
    // Delayed SCL-fall event: the moment sda_oe is allowed to change.
    assign hold_fire  = (hold_cnt == HW'(1));
    assign state_dbg  = state;

    // Two-flop synchronizers plus one history flop per line; idle bus is high.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            {scl_s1, scl_s2, scl_h} <= 3'b111;
            {sda_s1, sda_s2, sda_h} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_h} <= {scl_in, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_h} <= {sda_in, sda_s1, sda_s2};
        end
    end

    // Protocol FSM: START/STOP first, then SCL rise sampling and delayed fall actions.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            hold_cnt   <= '0;
            shift      <= 8'h00;
            tx_shift   <= 8'h00;
            rw         <= 1'b0;
            rx_pend    <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            tx_req    <= 1'b0;
            rx_valid  <= rx_pend;
            rx_pend   <= 1'b0;
            if (start_cond) begin
                state      <= ADDR;
                bit_cnt    <= 4'd0;
                hold_cnt   <= '0;
                addr_match <= 1'b0;
                sda_oe     <= 1'b0;
                start_det  <= 1'b1;
                busy       <= 1'b1;
            end else if (stop_cond) begin
                state      <= IDLE;
                bit_cnt    <= 4'd0;
                hold_cnt   <= '0;
                addr_match <= 1'b0;
                sda_oe     <= 1'b0;
                stop_det   <= 1'b1;
                busy       <= 1'b0;
            end else begin
                if (hold_cnt != '0)
                    hold_cnt <= hold_cnt - HW'(1);
                if (scl_fall && state != IDLE)
                    hold_cnt <= HOLD_LOAD;
                // Bit slot counter 0..8 (8 data bits then the ACK clock).
                if (scl_rise && state != IDLE && state != WAIT_STOP) begin
                    bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
                    shift   <= {shift[6:0], sda_s2};
                end
                case (state)
                    ADDR: begin
                        if (scl_rise && bit_cnt == 4'd7) begin
                            if (shift[6:0] == SLAVE_ADDR) begin
                                state <= ADDR_ACK;
                                rw    <= sda_s2;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK, RX_ACK: begin
                        if (state == ADDR_ACK && rw && scl_rise && bit_cnt == 4'd8)
                            tx_req <= 1'b1;
                        if (state == ADDR_ACK && rw && scl_fall && bit_cnt == 4'd0)
                            tx_shift <= tx_data;
                        if (hold_fire) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe     <= 1'b1;
                                addr_match <= 1'b1;
                            end else if (bit_cnt == 4'd0) begin
                                if (state == ADDR_ACK && rw) begin
                                    sda_oe <= ~tx_shift[7];
                                    state  <= TX_DATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= RX_DATA;
                                end
                            end
                        end
                    end
                    RX_DATA: begin
                        if (scl_rise && bit_cnt == 4'd7) begin
                            rx_data <= {shift[6:0], sda_s2};
                            rx_pend <= 1'b1;
                            state   <= RX_ACK;
                        end
                    end
                    TX_DATA: begin
                        if (hold_fire) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                sda_oe <= ~tx_shift[3'd7 - bit_cnt[2:0]];
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise && bit_cnt == 4'd8) begin
                            if (sda_s2)
                                state <= WAIT_STOP;
                            else
                                tx_req <= 1'b1;
                        end
                        if (scl_fall && bit_cnt == 4'd0)
                            tx_shift <= tx_data;
                        if (hold_fire && bit_cnt == 4'd0) begin
                            sda_oe <= ~tx_shift[7];
                            state  <= TX_DATA;
                        end
                    end
                    WAIT_STOP: sda_oe <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-banged master drives the open-drain
// bus, an event scoreboard checks the strobe outputs in order, and a timing
// monitor checks when sda_oe is allowed to move.
module tb_i2c_slave_responder;

    localparam int HOLD = 2;
    localparam int Q    = 8;   // core_clk cycles per quarter SCL period

    localparam logic [7:0] EV_START = 8'd1;
    localparam logic [7:0] EV_STOP  = 8'd2;
    localparam logic [7:0] EV_RX    = 8'd3;
    localparam logic [7:0] EV_TX    = 8'd4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RX_ACK    = 3'd4;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_line;
    logic       sda_oe, rx_valid, tx_req, addr_match, busy, start_det, stop_det;
    logic [7:0] rx_data;
    logic [2:0] state_dbg;

    logic [15:0] exp_q[$];
    logic [7:0]  tx_src_q[$];
    int n_vec = 0;
    int n_err = 0;

    assign sda_line = sda_m & ~sda_oe;

    // Clock/reset block
    always #5 clk = ~clk;

    i2c_slave_responder #(.SLAVE_ADDR(7'h10), .HOLD_CYCLES(HOLD)) dut (
        .core_clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_req(tx_req), .addr_match(addr_match),
        .busy(busy), .start_det(start_det), .stop_det(stop_det),
        .state_dbg(state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic ev_check(input logic [7:0] kind, input logic [7:0] data);
        logic [15:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d data %0h, expected nothing (t=%0t)", kind, data, $time);
        end else begin
            e = exp_q.pop_front();
            if (e !== {kind, data}) begin
                n_err++;
                $display("FAIL event: got kind %0d data %0h, expected kind %0d data %0h (t=%0t)",
                         kind, data, e[15:8], e[7:0], $time);
            end
        end
    endtask

    // Scoreboard monitor: every strobe pops the next expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (start_det) ev_check(EV_START, 8'h00);
                if (stop_det)  ev_check(EV_STOP, 8'h00);
                if (rx_valid)  ev_check(EV_RX, rx_data);
                if (tx_req) begin
                    ev_check(EV_TX, 8'h00);
                    if (tx_src_q.size() > 0) tx_data = tx_src_q.pop_front();
                end
            end
        end
    end

    // Timing monitor: sda_oe may only move HOLD cycles after the synced SCL fall.
    initial begin
        int   low_cnt;
        logic prev_oe;
        low_cnt = 0;
        prev_oe = 1'b0;
        forever begin
            @(negedge clk);
            if (scl) low_cnt = 0;
            else     low_cnt++;
            if (!reset && sda_oe !== prev_oe)
                check("hold_timing", 32'(low_cnt), 32'(HOLD + 4));
            prev_oe = sda_oe;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_bit(input logic b, output logic line);
        sda_m = b;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        line = sda_line;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic do_start();
        exp_q.push_back({EV_START, 8'h00});
        sda_m = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        check("busy_after_start", 32'(busy), 32'd1);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic do_stop();
        exp_q.push_back({EV_STOP, 8'h00});
        sda_m = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
        tick(Q);
        check("busy_after_stop", 32'(busy), 32'd0);
        check("addr_match_after_stop", 32'(addr_match), 32'd0);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack);
        logic line;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], line);
        bus_bit(1'b1, line);
        check($sformatf("ack_line_%02h", b), 32'(line), exp_ack ? 32'd0 : 32'd1);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic master_ack);
        logic       line;
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, line);
            d = {d[6:0], line};
        end
        bus_bit(master_ack ? 1'b0 : 1'b1, line);
        check($sformatf("read_data_%02h", exp), 32'(d), 32'(exp));
    endtask

    initial begin
        logic       line;
        logic [7:0] b6;

        // Reset values
        tick(6);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_addr_match", 32'(addr_match), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start_stop", 32'({start_det, stop_det}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        reset = 1'b0;
        tick(6);

        // 1: write one byte
        do_start();
        write_byte(8'h20, 1'b1);
        check("t1_addr_match", 32'(addr_match), 32'd1);
        exp_q.push_back({EV_RX, 8'h01});
        write_byte(8'h01, 1'b1);
        do_stop();

        // 2: foreign address is ignored
        do_start();
        write_byte(8'h22, 1'b0);
        check("t2_addr_match", 32'(addr_match), 32'd0);
        write_byte(8'h55, 1'b0);
        do_stop();

        // 3: read two bytes, ACK then NACK
        tx_src_q.push_back(8'hA5);
        tx_src_q.push_back(8'h3C);
        do_start();
        exp_q.push_back({EV_TX, 8'h00});
        exp_q.push_back({EV_TX, 8'h00});
        write_byte(8'h21, 1'b1);
        read_byte(8'hA5, 1'b1);
        read_byte(8'h3C, 1'b0);
        check("t3_wait_stop", 32'(state_dbg), 32'(S_WAIT_STOP));
        do_stop();
        check("t3_idle", 32'(state_dbg), 32'(S_IDLE));

        // 4: burst write 0x02..0x08
        do_start();
        write_byte(8'h20, 1'b1);
        for (int b = 2; b <= 8; b++) begin
            exp_q.push_back({EV_RX, 8'(b)});
            write_byte(8'(b), 1'b1);
        end
        do_stop();

        // 5: partial byte then repeated START into a read
        do_start();
        write_byte(8'h20, 1'b1);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, line);
        do_start();
        tx_src_q.push_back(8'h5A);
        exp_q.push_back({EV_TX, 8'h00});
        write_byte(8'h21, 1'b1);
        read_byte(8'h5A, 1'b0);
        do_stop();

        // 6: reset while the ACK is being driven
        do_start();
        write_byte(8'h20, 1'b1);
        b6 = 8'h99;
        exp_q.push_back({EV_RX, b6});
        for (int i = 7; i >= 0; i--) bus_bit(b6[i], line);
        sda_m = 1'b1;
        tick(2);
        check("t6_oe_before_reset", 32'(sda_oe), 32'd1);
        check("t6_state_rx_ack", 32'(state_dbg), 32'(S_RX_ACK));
        reset = 1'b1;
        tick(1);
        check("t6_oe_after_reset", 32'(sda_oe), 32'd0);
        check("t6_busy_after_reset", 32'(busy), 32'd0);
        check("t6_addr_match_after_reset", 32'(addr_match), 32'd0);
        check("t6_state_after_reset", 32'(state_dbg), 32'(S_IDLE));
        scl = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(6);
        do_start();
        write_byte(8'h20, 1'b1);
        exp_q.push_back({EV_RX, 8'h77});
        write_byte(8'h77, 1'b1);
        do_stop();

        tick(20);
        check("events_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
